// File: rtl/icg_pkg.sv
// ---------------------------------------------------------------------------
// icg_pkg
// Shared types and helpers for the clock-gated register bank.
//   icg_state_e : per-channel gating FSM state (RUN / HOLD / GATED)
//   STAT_W      : width of the optional per-channel gated-cycle counters
//   cnt_width() : width of the idle hysteresis counter for a given IDLE_CYC
// ---------------------------------------------------------------------------
package icg_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    GATED = 2'd2
  } icg_state_e;

  localparam int STAT_W = 16;

  // The counter must hold values up to IDLE_CYC-1. It is kept at least
  // one bit wide so IDLE_CYC=0 (gate immediately) still elaborates.
  function automatic int cnt_width(input int idle_cyc);
    return (idle_cyc < 2) ? 1 : $clog2(idle_cyc);
  endfunction

endpackage : icg_pkg

// File: rtl/icg_cell.sv
// ---------------------------------------------------------------------------
// icg_cell
// Latch-based integrated clock gate. The enable is captured by a latch that
// is transparent while clk is low and holds while clk is high, so gclk can
// only start or stop at a clk rising edge and never glitches.
// Kept as its own module so synthesis can swap in the library ICG cell.
// Ports:
//   clk      in  free-running clock
//   en       in  functional enable
//   test_en  in  scan/test override, forces the clock on
//   gclk     out gated clock
// ---------------------------------------------------------------------------
module icg_cell (
  input  logic clk,
  input  logic en,
  input  logic test_en,
  output logic gclk
);

  logic en_lat;

  // NOTE: this latch is intentional (it is the ICG). It is written with a
  // blocking assignment because it is level-sensitive logic, not an
  // edge-triggered register.
  always_latch begin
    if (!clk) en_lat = en | test_en;
  end

  assign gclk = en_lat & clk;

endmodule : icg_cell

// File: rtl/icg_reg_bank.sv
// ---------------------------------------------------------------------------
// icg_reg_bank
// Bank of NCH independently clock-gated W-bit registers. Each channel
// registers its activity request (act_r); a RUN/HOLD/GATED FSM with an
// idle hysteresis counter decides when that channel's clock may be stopped,
// so a channel that idles only briefly keeps its clock and does not chatter.
//
// Parameters:
//   NCH       number of channels
//   W         data width per channel
//   IDLE_CYC  idle cycles tolerated before gating (0 = gate immediately)
// Ports:
//   clk           in   free-running clock
//   rst           in   synchronous active-high reset (hold >= 2 cycles)
//   test_en       in   forces every channel clock on
//   in_vld        in   [NCH]   per-channel load request
//   d             in   [NCH*W] channel data, channel i = d[i*W +: W]
//   q             out  [NCH*W] registered data, clocked by gclk[i]
//   gated         out  [NCH]   1 = channel clock currently stopped
//   gated_cycles  out  [NCH*16] saturating gated-cycle counts
//                               (present only with ICG_STATS_EN defined)
// Build option: define ICG_STATS_EN to add the gated_cycles counters.
// ---------------------------------------------------------------------------
module icg_reg_bank
  import icg_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int W        = 8,
  parameter int IDLE_CYC = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             test_en,
  input  logic [NCH-1:0]   in_vld,
  input  logic [NCH*W-1:0] d,
  output logic [NCH*W-1:0] q,
  output logic [NCH-1:0]   gated
`ifdef ICG_STATS_EN
  ,
  output logic [NCH*STAT_W-1:0] gated_cycles
`endif
);

  localparam int CNT_W = cnt_width(IDLE_CYC);
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (IDLE_CYC == 0) ? '0 : CNT_W'(IDLE_CYC - 1);

  logic [NCH-1:0] act_r;
  logic [NCH-1:0] gclk;

  // Activity register runs on the free clock so a gated channel can wake.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) act_r <= '0;
    else     act_r <= in_vld;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch

    icg_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             en;
    logic [W-1:0]     q_r;

    always_ff @(posedge clk) begin
      if (rst) begin
        state <= RUN;
        cnt   <= '0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
      end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
        RUN: begin
          if (!act_r[i]) begin
            if (IDLE_CYC == 0) begin
              state_nxt = GATED;
            end else begin
              state_nxt = HOLD;
              cnt_nxt   = CNT_LOAD;
            end
          end
        end
        HOLD: begin
          // Activity wins over expiry when both happen together.
          if (act_r[i])        state_nxt = RUN;
          else if (cnt == '0)  state_nxt = GATED;
          else                 cnt_nxt   = cnt - CNT_W'(1);
        end
        GATED: begin
          if (act_r[i]) state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end

    // rst is in the enable so the synchronous clear always reaches q.
    assign en = rst | act_r[i] | (state != GATED);

    icg_cell u_icg (
      .clk     (clk),
      .en      (en),
      .test_en (test_en),
      .gclk    (gclk[i])
    );

    // NOTE: the data registers are reset; the bank's contents are
    // architecturally visible, so they must start from a known value.
    always_ff @(posedge gclk[i]) begin
      if (rst)           q_r <= '0;
      else if (act_r[i]) q_r <= d[i*W +: W];
    end

    assign q[i*W +: W] = q_r;

    // The clock is not stopped while test_en holds it on, even though the
    // FSM itself stays in GATED.
    assign gated[i] = (state == GATED) & ~act_r[i] & ~test_en;

`ifdef ICG_STATS_EN
    logic [STAT_W-1:0] stat;

    always_ff @(posedge clk) begin
      if (rst)                        stat <= '0;
      else if (gated[i] && stat != '1) stat <= stat + STAT_W'(1);
    end

    assign gated_cycles[i*STAT_W +: STAT_W] = stat;
`endif

  end : g_ch

endmodule : icg_reg_bank

// File: tb/tb_icg_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_icg_reg_bank
// Directed bench for icg_reg_bank (NCH=4, W=8, IDLE_CYC=3). The stimulus
// process pushes expected values tagged with the clk cycle they apply to;
// a monitor on the falling edge pops and compares them. A second monitor
// counts gated-clock edges and checks every gclk pulse is a full half period.
// ---------------------------------------------------------------------------
module tb_icg_reg_bank;

  localparam int NCH  = 4;
  localparam int W    = 8;
  localparam int HALF = 5;

  typedef enum int { K_Q, K_GATED, K_GCNT, K_STAT } kind_e;

  typedef struct {
    int          cyc;
    kind_e       kind;
    int          ch;
    logic [31:0] exp;
    string       name;
  } sb_item_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             test_en;
  logic [NCH-1:0]   in_vld;
  logic [NCH*W-1:0] d;
  logic [NCH*W-1:0] q;
  logic [NCH-1:0]   gated;
`ifdef ICG_STATS_EN
  logic [NCH*16-1:0] gated_cycles;
`endif

  icg_reg_bank #(.NCH(NCH), .W(W), .IDLE_CYC(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .test_en (test_en),
    .in_vld  (in_vld),
    .d       (d),
    .q       (q),
    .gated   (gated)
`ifdef ICG_STATS_EN
    ,
    .gated_cycles (gated_cycles)
`endif
  );

  always #HALF clk = ~clk;

  int       n_tests = 0;
  int       n_fail  = 0;
  int       cyc     = 0;
  sb_item_t sb[$];
  int       gcnt  [NCH];
  int       gbase [NCH];
  time      rise_t[NCH];
  logic [NCH-1:0] gclk_prev = '0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Gated-clock monitor: edge counts and pulse-width (glitch) check.
  initial for (int i = 0; i < NCH; i++) begin gcnt[i] = 0; rise_t[i] = 0; end

  always @(dut.gclk) begin
    for (int i = 0; i < NCH; i++) begin
      if (dut.gclk[i] && !gclk_prev[i]) begin
        gcnt[i]++;
        rise_t[i] = $time;
      end else if (!dut.gclk[i] && gclk_prev[i]) begin
        check($sformatf("gclk%0d_width", i), 32'($time - rise_t[i] >= HALF), 1);
      end
    end
    gclk_prev = dut.gclk;
  end

  // Scoreboard monitor.
  sb_item_t it;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      it = sb.pop_front();
      case (it.kind)
        K_Q:     check(it.name, 32'(q[it.ch*W +: W]), it.exp);
        K_GATED: check(it.name, 32'(gated), it.exp);
        K_GCNT:  check(it.name, 32'(gcnt[it.ch]), it.exp);
`ifdef ICG_STATS_EN
        K_STAT:  check(it.name, 32'(gated_cycles[it.ch*16 +: 16]), it.exp);
`endif
        default: check("sb_kind", 32'(it.kind), 32'(K_Q));
      endcase
    end
  end

  // Stimulus helpers: tick() returns 2 time units after a rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input kind_e k, input int ch, input logic [31:0] exp,
                      input string name);
    sb_item_t s;
    s.cyc = cyc; s.kind = k; s.ch = ch; s.exp = exp; s.name = name;
    sb.push_back(s);
  endtask

  task automatic exp_q(input string name, input int ch, input logic [W-1:0] v);
    push(K_Q, ch, 32'(v), name);
  endtask

  task automatic exp_gated(input string name, input logic [NCH-1:0] v);
    push(K_GATED, 0, 32'(v), name);
  endtask

  task automatic mark_gclk();
    for (int i = 0; i < NCH; i++) gbase[i] = gcnt[i];
  endtask

  task automatic exp_gcnt(input string name, input int ch, input int n);
    push(K_GCNT, ch, 32'(gbase[ch] + n), name);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; test_en = 1'b0; in_vld = '0; d = '1;

    // Reset held two cycles with all-ones data on the inputs.
    tick(); tick();                                   // cycle 2
    for (int i = 0; i < NCH; i++) exp_q($sformatf("reset_q%0d", i), i, 8'h00);
    exp_gated("reset_gated", 4'b0000);

    // Single-cycle load on channel 0.
    rst = 1'b0; in_vld[0] = 1'b1; d[7:0] = 8'hA5;
    tick();                                           // cycle 3
    exp_q("ch0_before_load", 0, 8'h00);
    in_vld = '0;
    tick();                                           // cycle 4
    exp_q("ch0_load", 0, 8'hA5);
    exp_q("ch1_untouched", 1, 8'h00);
    exp_q("ch2_untouched", 2, 8'h00);
    exp_q("ch3_untouched", 3, 8'h00);
    exp_gated("gated_c4", 4'b0000);
    tick(); exp_gated("gated_c5", 4'b0000);           // idle channels at cnt==0
    tick(); exp_gated("gated_c6", 4'b1110);           // channels 1..3 gated
    tick(); exp_gated("gated_c7", 4'b1110);           // ch0 still holding
    tick(); exp_gated("gated_c8", 4'b1111);           // 4 cycles after act_r fell

    // Gated channel 1: data toggles, no load, no clock.
    mark_gclk();
    for (int k = 0; k < 10; k++) begin
      d[15:8] = (k % 2 == 0) ? 8'h5A : 8'hC3;
      tick();                                         // cycles 9..18
    end
    exp_gcnt("ch1_no_gclk", 1, 0);
    exp_gcnt("ch3_no_gclk", 3, 0);
    exp_q("ch1_hold", 1, 8'h00);
    exp_gated("gated_c18", 4'b1111);

    // Wake channel 2, then re-activate it exactly when HOLD reaches cnt==0.
    in_vld[2] = 1'b1; d[23:16] = 8'h11;
    tick(); exp_gated("ch2_wake", 4'b1011);           // cycle 19
    in_vld = '0;
    tick(); exp_q("ch2_load1", 2, 8'h11);             // cycle 20
    mark_gclk();
    tick();                                           // cycle 21
    tick(); exp_gated("ch2_hold", 4'b1011);           // cycle 22
`ifdef ICG_STATS_EN
    push(K_STAT, 3, 32'd16, "ch3_stats_20_idle");
`endif
    in_vld[2] = 1'b1; d[23:16] = 8'h22;
    tick(); exp_gated("ch2_hold_cnt0", 4'b1011);      // cycle 23
    in_vld = '0;
    tick();                                           // cycle 24
    exp_q("ch2_load2", 2, 8'h22);
    exp_gated("ch2_back_run", 4'b1011);
    tick(); tick(); tick();                           // cycle 27
    exp_gated("gated_c27", 4'b1011);
    tick(); exp_gated("gated_c28", 4'b1111);          // cycle 28
    tick();                                           // cycle 29
    exp_gcnt("ch2_gclk_edges", 2, 8);
    exp_gcnt("ch0_gclk_edges", 0, 0);

    // Test override with every channel gated.
    test_en = 1'b1;
    mark_gclk();
    exp_gated("test_en_gated", 4'b0000);
    for (int k = 0; k < 8; k++) tick();               // cycles 30..37
    exp_q("test_en_q0", 0, 8'hA5);
    test_en = 1'b0;
    tick();                                           // cycle 38
    for (int i = 0; i < NCH; i++) exp_gcnt($sformatf("test_en_gclk%0d", i), i, 8);
    exp_q("after_test_q0", 0, 8'hA5);
    exp_q("after_test_q1", 1, 8'h00);
    exp_q("after_test_q2", 2, 8'h22);
    exp_q("after_test_q3", 3, 8'h00);
    exp_gated("after_test_gated", 4'b1111);

    // Reset while gated: rst must re-open the clocks and clear q.
    rst = 1'b1;
    mark_gclk();
    tick(); tick();                                   // cycle 40
    for (int i = 0; i < NCH; i++) begin
      exp_q($sformatf("rst2_q%0d", i), i, 8'h00);
      exp_gcnt($sformatf("rst2_gclk%0d", i), i, 2);
    end
    exp_gated("rst2_gated", 4'b0000);
`ifdef ICG_STATS_EN
    push(K_STAT, 3, 32'd0, "ch3_stats_cleared");
`endif
    rst = 1'b0;
    tick();
    @(negedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_icg_reg_bank
